// File: rtl/clk_mon_rst.sv
// clk_mon_rst: clock monitor and system reset sequencer in the clk_100M domain.
// Synchronises DCM lock and the divided 1 MHz / 100 kHz clocks, measures their
// periods, qualifies them and only then releases sys_rst. Produces 1-cycle
// tick enables for each divided clock.
// Optional feature: define CLKMON_BYPASS_EN to skip frequency qualification
// (LOCK_STABLE goes straight to RUN, only lock loss faults in RUN).
`timescale 1ns/1ps
module clk_mon_rst #(
   parameter int LOCK_STABLE_CYC = 1000,
   parameter int NOM_1M          = 100,
   parameter int NOM_100K        = 1000,
   parameter int TOL             = 2,
   parameter int TIMEOUT_CYC     = 5000
) (
   input  logic        clk_100M,
   input  logic        rst,
   input  logic        dcm_lock,
   input  logic        clk_1M_in,
   input  logic        clk_100K_in,
   output logic        sys_rst,
   output logic        clk_ok,
   output logic        tick_1M,
   output logic        tick_100K,
   output logic [1:0]  err_code,
   output logic [7:0]  per_1M,
   output logic [10:0] per_100K
);

   typedef enum logic [2:0] {
      WAIT_LOCK,
      LOCK_STABLE,
      CHECK,
      RUN,
      FAULT
   } state_t;

   localparam logic [7:0]  MIN_1M    = 8'(NOM_1M - TOL);
   localparam logic [7:0]  MAX_1M    = 8'(NOM_1M + TOL);
   localparam logic [10:0] MIN_100K  = 11'(NOM_100K - TOL);
   localparam logic [10:0] MAX_100K  = 11'(NOM_100K + TOL);
   localparam logic [15:0] STAB_LAST = 16'(LOCK_STABLE_CYC - 1);
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

   state_t      state_reg, state_next;
   logic [1:0]  err_reg, err_next;
   logic [15:0] tmr_reg;
   logic        sys_rst_reg, clk_ok_reg;
   logic [1:0]  lock_sync_reg;
   logic        lock_s;
   logic [7:0]  cnt_1M_reg, per_1M_reg;
   logic [10:0] cnt_100K_reg, per_100K_reg;

   // Index 0 = 1 MHz clock, index 1 = 100 kHz clock.
   logic [1:0]  clk_raw;
   logic [1:0]  tick_vec;
   logic [1:0]  in_vec;
   logic [1:0]  bad_vec;
   logic [1:0]  ok_vec;

   assign clk_raw = {clk_100K_in, clk_1M_in};
   assign lock_s  = lock_sync_reg[1];

   // Two-flop synchroniser for the asynchronous DCM lock.
   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) lock_sync_reg <= '0;
      else     lock_sync_reg <= {lock_sync_reg[0], dcm_lock};
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_edge
         logic [2:0] sync_reg;
         logic       tick_r;
         // Sync chain plus third flop; tick registered on the synced rising edge.
         always_ff @(posedge clk_100M or posedge rst) begin
            if (rst) begin
               sync_reg <= '0;
               tick_r   <= 1'b0;
            end else begin
               sync_reg <= {sync_reg[1:0], clk_raw[gi]};
               tick_r   <= sync_reg[1] & ~sync_reg[2];
            end
         end
         assign tick_vec[gi] = tick_r;
      end
   endgenerate

   // 1 MHz period counter: capture on tick, otherwise saturating count.
   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         cnt_1M_reg <= '0;
         per_1M_reg <= '0;
      end else if (tick_vec[0]) begin
         per_1M_reg <= cnt_1M_reg;
         cnt_1M_reg <= 8'd1;
      end else if (cnt_1M_reg != 8'hFF) begin
         cnt_1M_reg <= cnt_1M_reg + 8'd1;
      end
   end

   // 100 kHz period counter: capture on tick, otherwise saturating count.
   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         cnt_100K_reg <= '0;
         per_100K_reg <= '0;
      end else if (tick_vec[1]) begin
         per_100K_reg <= cnt_100K_reg;
         cnt_100K_reg <= 11'd1;
      end else if (cnt_100K_reg != 11'h7FF) begin
         cnt_100K_reg <= cnt_100K_reg + 11'd1;
      end
   end

   // A period is bad when it closes out of range, or when the running count
   // already exceeds the maximum (clock missing, no need to wait for a tick).
   assign in_vec[0]  = (cnt_1M_reg >= MIN_1M) && (cnt_1M_reg <= MAX_1M);
   assign in_vec[1]  = (cnt_100K_reg >= MIN_100K) && (cnt_100K_reg <= MAX_100K);
   assign bad_vec[0] = (tick_vec[0] && !in_vec[0]) || (cnt_1M_reg > MAX_1M);
   assign bad_vec[1] = (tick_vec[1] && !in_vec[1]) || (cnt_100K_reg > MAX_100K);

   generate
      for (gi = 0; gi < 2; gi++) begin : g_qual
         logic       seen_r;
         logic [1:0] good_r;
         // CHECK qualification: drop the first tick, then need 2 good periods in a row.
         always_ff @(posedge clk_100M or posedge rst) begin
            if (rst) begin
               seen_r <= 1'b0;
               good_r <= '0;
            end else if (state_reg != CHECK) begin
               seen_r <= 1'b0;
               good_r <= '0;
            end else if (tick_vec[gi] && !seen_r) begin
               seen_r <= 1'b1;
            end else if (bad_vec[gi]) begin
               good_r <= '0;
            end else if (tick_vec[gi] && (good_r != 2'd2)) begin
               good_r <= good_r + 2'd1;
            end
         end
         assign ok_vec[gi] = (good_r == 2'd2);
      end
   endgenerate

   // Next-state and error-code decision.
   always_comb begin
      state_next = state_reg;
      err_next   = err_reg;
      case (state_reg)
         WAIT_LOCK: begin
            if (lock_s) state_next = LOCK_STABLE;
         end
         LOCK_STABLE: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
            end else if (tmr_reg == STAB_LAST) begin
`ifdef CLKMON_BYPASS_EN
               state_next = RUN;
               err_next   = 2'b00;
`else
               state_next = CHECK;
`endif
            end
         end
         CHECK: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
            end else if (ok_vec == 2'b11) begin
               state_next = RUN;
               err_next   = 2'b00;
            end else if (tmr_reg == TMO_LAST) begin
               state_next = FAULT;
               err_next   = ok_vec[0] ? 2'b10 : 2'b01;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_next = FAULT;
               err_next   = 2'b11;
            end
`ifndef CLKMON_BYPASS_EN
            else if (bad_vec[0]) begin
               state_next = FAULT;
               err_next   = 2'b01;
            end else if (bad_vec[1]) begin
               state_next = FAULT;
               err_next   = 2'b10;
            end
`endif
         end
         FAULT: begin
            if (tmr_reg == TMO_LAST) state_next = WAIT_LOCK;
         end
         default: state_next = WAIT_LOCK;
      endcase
   end

   // State, shared stability/timeout timer (cleared on every state change), outputs.
   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         state_reg   <= WAIT_LOCK;
         err_reg     <= 2'b00;
         tmr_reg     <= '0;
         sys_rst_reg <= 1'b1;
         clk_ok_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         err_reg     <= err_next;
         sys_rst_reg <= (state_next != RUN);
         clk_ok_reg  <= (state_next == RUN);
         if (state_next != state_reg) tmr_reg <= '0;
         else if (tmr_reg != 16'hFFFF) tmr_reg <= tmr_reg + 16'd1;
      end
   end

   assign sys_rst   = sys_rst_reg;
   assign clk_ok    = clk_ok_reg;
   assign tick_1M   = tick_vec[0];
   assign tick_100K = tick_vec[1];
   assign err_code  = err_reg;
   assign per_1M    = per_1M_reg;
   assign per_100K  = per_100K_reg;

endmodule

// File: tb/tb_clk_mon_rst.sv
// tb_clk_mon_rst: directed testbench for clk_mon_rst.
// Cycle numbers are posedges of clk_100M counted from reset release
// (release happens on a negedge, so the first following posedge is cycle 1).
`timescale 1ns/1ps
module tb_clk_mon_rst;

   logic        clk_100M = 1'b0;
   logic        rst = 1'b1;
   logic        dcm_lock = 1'b0;
   logic        clk_1M_in = 1'b0;
   logic        clk_100K_in = 1'b0;
   logic        sys_rst, clk_ok, tick_1M, tick_100K;
   logic [1:0]  err_code;
   logic [7:0]  per_1M;
   logic [10:0] per_100K;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   int mark = 0;
   int per1 = 100;
   int per100k = 1000;
   bit run_100k = 1'b1;
   int last_tick_100k = 0;

   clk_mon_rst dut (
      .clk_100M    (clk_100M),
      .rst         (rst),
      .dcm_lock    (dcm_lock),
      .clk_1M_in   (clk_1M_in),
      .clk_100K_in (clk_100K_in),
      .sys_rst     (sys_rst),
      .clk_ok      (clk_ok),
      .tick_1M     (tick_1M),
      .tick_100K   (tick_100K),
      .err_code    (err_code),
      .per_1M      (per_1M),
      .per_100K    (per_100K)
   );

   always #5 clk_100M = ~clk_100M;

   always @(posedge clk_100M) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk_100M) if (tick_100K) last_tick_100k = cyc_cnt;

   // Divided clocks, offset so their edges never coincide with clk_100M edges.
   initial begin
      #2;
      forever begin
         clk_1M_in = 1'b1; #(per1 * 5);
         clk_1M_in = 1'b0; #(per1 * 5);
      end
   end

   initial begin
      #3;
      forever begin
         if (run_100k) begin
            clk_100K_in = 1'b1; #(per100k * 5);
            clk_100K_in = 1'b0; #(per100k * 5);
         end else begin
            clk_100K_in = 1'b0; #10;
         end
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk_100M);
      @(negedge clk_100M);
      rst = 1'b0;
      mark = cyc_cnt;
   endtask

   task automatic wait_run(input int bound, output bit ok, output int at);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk_100M);
         if (sys_rst === 1'b0) begin
            ok = 1'b1;
            at = cyc_cnt - mark;
            break;
         end
      end
   endtask

   task automatic wait_err(input int bound, output bit ok, output int at);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk_100M);
         if (err_code !== 2'b00) begin
            ok = 1'b1;
            at = cyc_cnt - mark;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk_100M);
      @(negedge clk_100M);
      $display("test_reset: sys_rst=%0b clk_ok=%0b err=%0b", sys_rst, clk_ok, err_code);
      checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
      checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL reset_clk_ok: got %b expected 0", clk_ok); end
      checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err_code); end
      checks++; if (per_1M !== 8'd0) begin errors++; $display("FAIL reset_per_1M: got %0d expected 0", per_1M); end
      checks++; if (per_100K !== 11'd0) begin errors++; $display("FAIL reset_per_100K: got %0d expected 0", per_100K); end
      checks++; if ({tick_1M, tick_100K} !== 2'b00) begin errors++; $display("FAIL reset_ticks: got %b expected 00", {tick_1M, tick_100K}); end
   endtask

   task automatic test_nominal();
      bit ok;
      int at, n1, n100;
      dcm_lock = 1'b1;
      per1 = 100;
      do_reset(10);
      wait_run(4010, ok, at);
      $display("test_nominal: RUN reached=%0b at cycle %0d", ok, at);
      checks++; if (!ok) begin errors++; $display("FAIL nominal_run: sys_rst still %b after 4010 cycles, expected 0", sys_rst); end
      checks++; if (clk_ok !== 1'b1) begin errors++; $display("FAIL nominal_clk_ok: got %b expected 1", clk_ok); end
      checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL nominal_err: got %b expected 00", err_code); end
      repeat (2100) @(negedge clk_100M);
      checks++; if (per_1M !== 8'd100) begin errors++; $display("FAIL nominal_per_1M: got %0d expected 100", per_1M); end
      checks++; if (per_100K !== 11'd1000) begin errors++; $display("FAIL nominal_per_100K: got %0d expected 1000", per_100K); end
      n1 = 0;
      n100 = 0;
      repeat (1000) begin
         @(negedge clk_100M);
         n1 += int'(tick_1M);
         n100 += int'(tick_100K);
      end
      $display("test_nominal: ticks in 1000 cycles 1M=%0d 100K=%0d", n1, n100);
      checks++; if (n1 != 10) begin errors++; $display("FAIL nominal_tick_1M: got %0d expected 10", n1); end
      checks++; if (n100 != 1) begin errors++; $display("FAIL nominal_tick_100K: got %0d expected 1", n100); end
      checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL nominal_stay_run: got %b expected 0", sys_rst); end
   endtask

   task automatic test_100k_stuck();
      bit ok;
      int at, delta;
      run_100k = 1'b0;
      wait_err(3000, ok, at);
      delta = cyc_cnt - last_tick_100k;
      $display("test_100k_stuck: err=%b after %0d cycles from last tick", err_code, delta);
      checks++; if (!ok) begin errors++; $display("FAIL stuck_timeout: err_code %b, expected a fault", err_code); end
      checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL stuck_err: got %b expected 10", err_code); end
      checks++; if (clk_ok !== 1'b0 || sys_rst !== 1'b1) begin errors++; $display("FAIL stuck_outputs: clk_ok=%b sys_rst=%b expected 0/1", clk_ok, sys_rst); end
      checks++; if (delta < 1003 || delta > 1006) begin errors++; $display("FAIL stuck_latency: got %0d expected 1003..1006", delta); end
      run_100k = 1'b1;
   endtask

   task automatic test_lock_drop();
      bit ok;
      int at, n;
      dcm_lock = 1'b1;
      do_reset(10);
      wait_run(4010, ok, at);
      checks++; if (!ok) begin errors++; $display("FAIL lockdrop_run: sys_rst %b, expected 0", sys_rst); end
      dcm_lock = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_100M);
         n++;
         if (sys_rst === 1'b1) break;
      end
      $display("test_lock_drop: sys_rst=1 after %0d cycles err=%b", n, err_code);
      checks++; if (sys_rst !== 1'b1 || n > 3) begin errors++; $display("FAIL lockdrop_latency: got %0d cycles (sys_rst=%b) expected <=3", n, sys_rst); end
      checks++; if (err_code !== 2'b11) begin errors++; $display("FAIL lockdrop_err: got %b expected 11", err_code); end
      checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL lockdrop_clk_ok: got %b expected 0", clk_ok); end
      dcm_lock = 1'b1;
   endtask

   task automatic test_rst_mid_run();
      bit ok;
      int at, low_seen;
      dcm_lock = 1'b1;
      do_reset(10);
      wait_run(4010, ok, at);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_run: sys_rst %b, expected 0", sys_rst); end
      repeat (300) @(negedge clk_100M);
      checks++; if (per_1M !== 8'd100) begin errors++; $display("FAIL rstmid_pre_per_1M: got %0d expected 100", per_1M); end
      @(posedge clk_100M);
      #3 rst = 1'b1;
      #1;
      $display("test_rst_mid_run: async reset sys_rst=%b clk_ok=%b per_1M=%0d per_100K=%0d", sys_rst, clk_ok, per_1M, per_100K);
      checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL rstmid_sys_rst: got %b expected 1", sys_rst); end
      checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL rstmid_clk_ok: got %b expected 0", clk_ok); end
      checks++; if (per_1M !== 8'd0 || per_100K !== 11'd0) begin errors++; $display("FAIL rstmid_per: got %0d/%0d expected 0/0", per_1M, per_100K); end
      do_reset(5);
      low_seen = 0;
      repeat (1000) begin
         @(negedge clk_100M);
         if (sys_rst !== 1'b1) low_seen++;
      end
      checks++; if (low_seen != 0) begin errors++; $display("FAIL rstmid_restart: sys_rst low %0d cycles early, expected 0", low_seen); end
      wait_run(3100, ok, at);
      $display("test_rst_mid_run: RUN again=%0b at cycle %0d", ok, at);
      checks++; if (!ok || err_code !== 2'b00) begin errors++; $display("FAIL rstmid_rerun: run=%0b err=%b expected 1/00", ok, err_code); end
   endtask

   task automatic test_freq_fault();
      bit ok;
      int at;
      per1 = 104;
      dcm_lock = 1'b1;
      do_reset(10);
      wait_err(7000, ok, at);
      $display("test_freq_fault: err=%b at cycle %0d per_1M=%0d", err_code, at, per_1M);
      checks++; if (!ok || at != 6003) begin errors++; $display("FAIL freq_fault_time: got %0d expected 6003", at); end
      checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL freq_fault_err: got %b expected 01", err_code); end
      checks++; if (per_1M !== 8'd104) begin errors++; $display("FAIL freq_fault_per: got %0d expected 104", per_1M); end
      checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL freq_fault_sys_rst: got %b expected 1", sys_rst); end
      per1 = 100;
      repeat (4990) @(negedge clk_100M);
      checks++; if (err_code !== 2'b01 || sys_rst !== 1'b1) begin errors++; $display("FAIL freq_hold: err=%b sys_rst=%b expected 01/1", err_code, sys_rst); end
      wait_run(4100, ok, at);
      $display("test_freq_fault: retry RUN=%0b at cycle %0d err=%b", ok, at, err_code);
      checks++; if (!ok || at < 14006 || at > 15010) begin errors++; $display("FAIL freq_retry_time: got %0d expected 14006..15010", at); end
      checks++; if (err_code !== 2'b00 || clk_ok !== 1'b1) begin errors++; $display("FAIL freq_retry_state: err=%b clk_ok=%b expected 00/1", err_code, clk_ok); end
   endtask

   task automatic test_lock_glitch();
      bit ok;
      int at;
      // A 104-cycle 1 MHz period forces a deterministic CHECK timeout, so
      // the fault time pins down exactly when CHECK was entered.
      per1 = 104;
      dcm_lock = 1'b1;
      do_reset(10);
      repeat (502) @(negedge clk_100M);
      dcm_lock = 1'b0;
      @(negedge clk_100M);
      dcm_lock = 1'b1;
      wait_err(8000, ok, at);
      $display("test_lock_glitch: err=%b at cycle %0d", err_code, at);
      checks++; if (!ok || at != 6506) begin errors++; $display("FAIL glitch_fault_time: got %0d expected 6506", at); end
      checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL glitch_err: got %b expected 01", err_code); end
      per1 = 100;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_100k_stuck();
      test_lock_drop();
      test_rst_mid_run();
      test_freq_fault();
      test_lock_glitch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
